// File: rtl/core_lsu.sv
// Memory-stage load/store unit: issues one aligned access at a time on the
// request/grant/response data bus and stalls the pipeline until it completes.
module core_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_load_valid,
    output logic            o_misaligned,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state, state_next;
    logic              is_load, is_store, f3_ok, mem_op, mis;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [XLEN-1:0]   load_ext;

    // Decode of the instruction currently presented to the MEM stage.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_load  = (i_opcode == OP_LOAD);
        is_store = (i_opcode == OP_STORE);
        f3_ok    = 1'b0;
        mis      = 1'b0;
        be_c     = 4'b1111;
        wdata_c  = i_store_data;
        if (is_load)
            f3_ok = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                    (i_funct3 == 3'd4) || (i_funct3 == 3'd5);
        else if (is_store)
            f3_ok = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2);
        case (i_funct3)
            3'd0, 3'd4: begin
                be_c    = 4'b0001 << i_addr[1:0];
                wdata_c = {4{i_store_data[7:0]}};
            end
            3'd1, 3'd5: begin
                be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{i_store_data[15:0]}};
                mis     = i_addr[0];
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = i_store_data;
                mis     = (i_addr[1:0] != 2'b00);
            end
        endcase
        mem_op = i_valid && (is_load || is_store) && f3_ok;
    end

    always_comb begin
        state_next   = state;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        case (state)
            IDLE: begin
                o_misaligned = mem_op && mis;
                o_stall      = mem_op && !mis;
                if (mem_op && !mis)
                    state_next = REQ;
            end
            REQ: begin
                o_stall = 1'b1;
                if (i_dmem_gnt)
                    state_next = RESP;
            end
            RESP: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        rbyte = i_dmem_rdata[{off_q, 3'b000} +: 8];
        rhalf = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    load_ext = {{24{rbyte[7]}}, rbyte};
            3'd4:    load_ext = {24'd0, rbyte};
            3'd1:    load_ext = {{16{rhalf[15]}}, rhalf};
            3'd5:    load_ext = {16'd0, rhalf};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    // Bus fields stay latched after grant; only the request line drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'b0000;
            o_dmem_wdata <= '0;
            o_load_data  <= '0;
            o_load_valid <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !mis) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= is_store;
                        o_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_dmem_be    <= be_c;
                        o_dmem_wdata <= wdata_c;
                        f3_q         <= i_funct3;
                        off_q        <= i_addr[1:0];
                    end
                end
                REQ: begin
                    if (i_dmem_gnt)
                        o_dmem_req <= 1'b0;
                end
                RESP: begin
                    if (i_dmem_rvalid) begin
                        o_load_valid <= !o_dmem_we;
                        if (!o_dmem_we)
                            o_load_data <= load_ext;
                    end
                end
                default: o_load_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Directed self-checking bench for core_lsu: loads, stores, wait states,
// misalignment and mid-access reset.
module tb_core_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        o_misaligned;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    core_lsu #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
        .o_stall(o_stall), .o_load_data(o_load_data), .o_load_valid(o_load_valid),
        .o_misaligned(o_misaligned), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One full access from IDLE; checks stall/bus every cycle, then DONE result.
    task automatic access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int gnt_wait, input int rv_wait, input logic stray_rv,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_addr = addr; i_store_data = sd;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = rdata;
        #1;
        chk({tag, " issue stall"}, o_stall, 1);
        chk({tag, " issue misaligned"}, o_misaligned, 0);
        chk({tag, " issue req"}, o_dmem_req, 0);
        tick();
        for (int k = 0; k <= gnt_wait; k++) begin
            i_dmem_gnt    = (k == gnt_wait);
            i_dmem_rvalid = (k == gnt_wait) && stray_rv;
            #1;
            chk({tag, " req"}, o_dmem_req, 1);
            chk({tag, " req stall"}, o_stall, 1);
            chk({tag, " addr"}, o_dmem_addr, {addr[31:2], 2'b00});
            chk({tag, " be"}, o_dmem_be, exp_be);
            chk({tag, " we"}, o_dmem_we, op == STORE);
            if (op == STORE) chk({tag, " wdata"}, o_dmem_wdata, exp_wdata);
            tick();
        end
        i_dmem_gnt = 1'b0;
        for (int k = 0; k <= rv_wait; k++) begin
            i_dmem_rvalid = (k == rv_wait);
            #1;
            chk({tag, " resp stall"}, o_stall, 1);
            chk({tag, " resp req low"}, o_dmem_req, 0);
            chk({tag, " resp load_valid"}, o_load_valid, 0);
            tick();
        end
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h5555_AAAA;
        #1;
        chk({tag, " done stall"}, o_stall, 0);
        chk({tag, " done load_valid"}, o_load_valid, op == LOAD);
        if (op == LOAD) chk({tag, " load_data"}, o_load_data, exp_load);
        tick();
        i_valid = 1'b0;
        #1;
        chk({tag, " idle load_valid"}, o_load_valid, 0);
        chk({tag, " idle stall"}, o_stall, 0);
        if (op == LOAD) chk({tag, " load_data hold"}, o_load_data, exp_load);
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_opcode = 7'd0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_store_data = 32'd0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
        #2;
        chk("rst req", o_dmem_req, 0);
        chk("rst addr", o_dmem_addr, 0);
        chk("rst be", o_dmem_be, 0);
        chk("rst load_data", o_load_data, 0);
        chk("rst load_valid", o_load_valid, 0);
        chk("rst stall", o_stall, 0);
        tick();
        i_rst_n = 1'b1;
        tick();

        access("LW100", LOAD, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF,
               4'b1111, 32'h0, 32'hDEADBEEF);
        access("LB103", LOAD, 3'd0, 32'h103, 32'h0, 0, 0, 1'b0, 32'h80FF_1234,
               4'b1000, 32'h0, 32'hFFFFFF80);
        access("LBU103", LOAD, 3'd4, 32'h103, 32'h0, 0, 0, 1'b0, 32'h80FF_1234,
               4'b1000, 32'h0, 32'h00000080);
        access("LH102", LOAD, 3'd1, 32'h102, 32'h0, 0, 0, 1'b0, 32'h80FF_1234,
               4'b1100, 32'h0, 32'hFFFF80FF);
        access("LHU102", LOAD, 3'd5, 32'h102, 32'h0, 0, 0, 1'b0, 32'h80FF_1234,
               4'b1100, 32'h0, 32'h000080FF);
        access("SB201", STORE, 3'd0, 32'h201, 32'h000000AB, 0, 0, 1'b0, 32'h0,
               4'b0010, 32'hABABABAB, 32'h0);
        access("SH202", STORE, 3'd1, 32'h202, 32'h00001234, 0, 0, 1'b0, 32'h0,
               4'b1100, 32'h12341234, 32'h0);
        access("LB100", LOAD, 3'd0, 32'h100, 32'h0, 0, 0, 1'b0, 32'h1122_3344,
               4'b0001, 32'h0, 32'h00000044);
        access("SW300", STORE, 3'd2, 32'h300, 32'hCAFEF00D, 2, 1, 1'b0, 32'h0,
               4'b1111, 32'hCAFEF00D, 32'h0);
        // Grant withheld 5 cycles, response 3 cycles later, stray rvalid with grant.
        access("LWwait", LOAD, 3'd2, 32'h104, 32'h0, 5, 3, 1'b1, 32'h1234_5678,
               4'b1111, 32'h0, 32'h12345678);

        // Misaligned accesses never reach the bus.
        i_valid = 1'b1; i_opcode = LOAD; i_funct3 = 3'd2; i_addr = 32'h102;
        #1;
        chk("LWmis flag", o_misaligned, 1);
        chk("LWmis stall", o_stall, 0);
        tick();
        chk("LWmis req", o_dmem_req, 0);
        i_opcode = STORE; i_funct3 = 3'd1; i_addr = 32'h101; i_store_data = 32'h5678;
        #1;
        chk("SHmis flag", o_misaligned, 1);
        chk("SHmis stall", o_stall, 0);
        tick();
        chk("SHmis req", o_dmem_req, 0);
        // Unsupported funct3: no access, no stall, no flag.
        i_opcode = LOAD; i_funct3 = 3'd3; i_addr = 32'h100;
        #1;
        chk("badf3 flag", o_misaligned, 0);
        chk("badf3 stall", o_stall, 0);
        tick();
        chk("badf3 req", o_dmem_req, 0);
        i_valid = 1'b0;
        tick();

        // Reset while waiting for the response.
        i_valid = 1'b1; i_opcode = LOAD; i_funct3 = 3'd2; i_addr = 32'h400;
        tick();
        i_dmem_gnt = 1'b1;
        tick();
        i_dmem_gnt = 1'b0; i_valid = 1'b0;
        #1;
        chk("pre-rst resp stall", o_stall, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst req", o_dmem_req, 0);
        chk("midrst addr", o_dmem_addr, 0);
        chk("midrst be", o_dmem_be, 0);
        chk("midrst we", o_dmem_we, 0);
        chk("midrst wdata", o_dmem_wdata, 0);
        chk("midrst load_data", o_load_data, 0);
        chk("midrst load_valid", o_load_valid, 0);
        chk("midrst stall", o_stall, 0);
        tick();
        i_rst_n = 1'b1;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hBAD0BAD0;
        tick();
        i_dmem_rvalid = 1'b0;
        #1;
        chk("stray rv load_valid", o_load_valid, 0);
        chk("stray rv stall", o_stall, 0);
        chk("stray rv load_data", o_load_data, 0);
        tick();
        access("LWpost", LOAD, 3'd2, 32'h108, 32'h0, 1, 0, 1'b0, 32'h0BADF00D,
               4'b1111, 32'h0, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
